exc_return_ctrl: RTL and testbench
==================================

Name: exc_return_ctrl

Overview:
- Sequential exception-entry / exception-return controller for the refcpu CP0 path.
- Owns Status.EXL/ERL, EPC, ErrorEPC and Cause.BD/ExcCode, and issues a PC redirect to fetch through a valid/ready handshake.
- ERET in a delay slot raises a Reserved Instruction (RI) exception instead of halting.
- Parametrised nesting stack: saves EPC/BD on exceptions taken while EXL=1, and restores them on ERET.

Parameters:
- NEST_DEPTH, 4, entries in the EPC/BD save stack; 0 selects standard MIPS behaviour (EPC frozen while EXL=1).
- EXC_VECTOR, 32'hBFC0_0380, general exception vector.
- ADDR_W, 32, PC/EPC width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- exc_valid  in  1  exception request from the commit stage.
- exc_code  in  5  Cause.ExcCode of the request.
- exc_pc  in  ADDR_W  PC of the faulting instruction.
- exc_delay  in  1  faulting instruction is in a delay slot.
- eret_valid  in  1  ERET request.
- eret_pc  in  ADDR_W  PC of the ERET.
- eret_delay  in  1  ERET is in a delay slot.
- req_ready  out  1  requests accepted this cycle; equals (state==IDLE).
- wr_en  in  1  mtc0 write enable.
- wr_addr  in  5  CP0 register number: 12 Status, 14 EPC, 30 ErrorEPC.
- wr_data  in  ADDR_W  write data; Status uses bit1=EXL, bit2=ERL.
- redirect_valid  out  1  redirect pending.
- redirect_pc  out  ADDR_W  redirect target.
- redirect_ready  in  1  fetch accepts the redirect.
- status_exl, status_erl  out  1 each  current bits.
- epc, error_epc  out  ADDR_W  current registers.
- cause_bd  out  1  current Cause.BD.
- cause_code  out  5  current Cause.ExcCode.
- nest_level  out  $clog2(NEST_DEPTH+1)  stack occupancy.
- nest_ovf  out  1  sticky overflow flag.

Behaviour:
- Reset values:
  - state IDLE, redirect_valid 0, redirect_pc 0.
  - ERL 1, EXL 0, EPC 0, ErrorEPC 0, BD 0, ExcCode 0.
  - nest_level 0, nest_ovf 0, stack contents don't-care.
- Reset asserted in REDIRECT aborts the redirect; no handshake completes.
- States: IDLE, REDIRECT.
  - IDLE -> REDIRECT on an accepted exc_valid or eret_valid.
  - REDIRECT -> IDLE on redirect_valid && redirect_ready.
  - Requests are ignored, not queued, while in REDIRECT.
- Latency: a request accepted at edge t updates the registers and raises redirect_valid after edge t; redirect_pc is held stable until the handshake completes.
- Simultaneous exc_valid and eret_valid: the exception wins and the ERET is dropped.
- Exception entry (or ERET with eret_delay=1, which is treated as ExcCode 5'h0A using eret_pc/eret_delay):
  - EXL=0: EPC = delay ? pc-4 : pc; BD = delay; EXL 1; ExcCode updated.
  - EXL=1, NEST_DEPTH>0, nest_level<NEST_DEPTH: push {EPC,BD}; nest_level+1; then update as in the EXL=0 case.
  - EXL=1 and stack full, or NEST_DEPTH=0: EPC/BD unchanged; ExcCode updated; nest_ovf set if NEST_DEPTH>0.
  - Redirect target EXC_VECTOR in all cases.
- ERET (eret_delay=0):
  - ERL=1: target ErrorEPC; ERL 0; EXL and stack untouched.
  - Else, nest_level>0: target EPC; pop {EPC,BD} from top; nest_level-1; EXL stays 1.
  - Else: target EPC; EXL 0.
- PC arithmetic is mod 2^ADDR_W: pc-4 wraps (exc_pc 0 with delay gives all-ones minus 3).
- mtc0 write:
  - Applied at the edge unless a request is accepted the same cycle; in that case the write is discarded (the pipeline is being flushed).
  - Writing EPC replaces the current EPC only, never stack entries.
  - Writes to other addresses are ignored.
- nest_ovf clears only on reset.

Decomposition:
- Shared package (refcpu defs):
  - exc_code_t enum, including RI = 5'h0A.
  - CP0 register number constants for Status/EPC/ErrorEPC.
  - Status bit index constants for EXL/ERL.
  - Redirect state enum.
- Sub-module nest_stack:
  - Parametrised LIFO of {ADDR_W+1} bits with push, pop and level outputs.
  - Generate-skipped when NEST_DEPTH=0.

Test Plan:
- Reset release, then eret_valid with eret_pc 0x100 -> ERL=1 path: redirect_pc 0 (ErrorEPC); ERL 0; redirect held across 3 cycles of redirect_ready=0.
- ERL=0, EXL=0; exc_valid code 4, pc 0x8000_1004, delay=1 -> EPC 0x8000_1000, BD 1, EXL 1, redirect_pc 0xBFC0_0380; then ERET -> redirect_pc 0x8000_1000, EXL 0.
- NEST_DEPTH=2: five nested exceptions at pcs 0x10, 0x20, 0x30, 0x40, 0x50 -> nest_level 2, EPC 0x30, nest_ovf 1; three ERETs -> targets 0x30, 0x20, 0x10; EXL 0 after the third.
- ERET with eret_delay=1, eret_pc 0x200 -> ExcCode 0x0A, EPC 0x1FC, BD 1, redirect to vector.
- Same-cycle exc_valid (pc 0x40) and eret_valid -> exception taken, EPC 0x40; same-cycle mtc0 EPC=0x999 discarded.
- Request during REDIRECT ignored (EPC unchanged); reset mid-REDIRECT -> redirect_valid 0 and ERL 1 next cycle.

Source files
------------

// File: rtl/exc_return_ctrl_pkg.sv
// Shared refcpu CP0 definitions: exception codes, CP0 register numbers,
// Status bit positions and the redirect FSM state type.
package exc_return_ctrl_pkg;

  typedef enum logic [4:0] {
    EXC_INT  = 5'h00,
    EXC_MOD  = 5'h01,
    EXC_TLBL = 5'h02,
    EXC_TLBS = 5'h03,
    EXC_ADEL = 5'h04,
    EXC_ADES = 5'h05,
    EXC_IBE  = 5'h06,
    EXC_DBE  = 5'h07,
    EXC_SYS  = 5'h08,
    EXC_BP   = 5'h09,
    EXC_RI   = 5'h0A,
    EXC_CPU  = 5'h0B,
    EXC_OV   = 5'h0C,
    EXC_TR   = 5'h0D
  } exc_code_t;

  localparam logic [4:0] CP0_STATUS    = 5'd12;
  localparam logic [4:0] CP0_EPC       = 5'd14;
  localparam logic [4:0] CP0_ERROR_EPC = 5'd30;

  localparam int unsigned STATUS_EXL_BIT = 1;
  localparam int unsigned STATUS_ERL_BIT = 2;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } redir_state_t;

endpackage

// File: rtl/exc_return_ctrl_nest_stack.sv
// LIFO holding saved {EPC,BD} pairs for nested exceptions; the top entry is
// read combinationally so a pop can restore it in the same cycle.
module exc_return_ctrl_nest_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 33,
  parameter int unsigned LVL_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     push_data,
  output logic [W-1:0]     top_data,
  output logic [LVL_W-1:0] level
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [LVL_W-1:0] r_level;
  logic [IDX_W-1:0] w_wr_idx;
  logic [IDX_W-1:0] w_rd_idx;
  logic             w_full;
  logic             w_empty;

  assign w_full   = (r_level == LVL_W'(DEPTH));
  assign w_empty  = (r_level == '0);
  assign w_wr_idx = IDX_W'(r_level);
  assign w_rd_idx = IDX_W'(r_level - LVL_W'(1));
  assign top_data = r_mem[w_rd_idx];
  assign level    = r_level;

  // Contents need no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push && !w_full) begin
      r_mem[w_wr_idx] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_level <= '0;
    end else if (push && !w_full) begin
      r_level <= r_level + LVL_W'(1);
    end else if (pop && !w_empty) begin
      r_level <= r_level - LVL_W'(1);
    end
  end

endmodule

// File: rtl/exc_return_ctrl.sv
// CP0 exception entry / ERET controller: owns EXL/ERL, EPC, ErrorEPC, Cause
// BD/ExcCode, a nesting save stack, and a valid/ready PC redirect to fetch.
module exc_return_ctrl
  import exc_return_ctrl_pkg::*;
#(
  parameter int unsigned          ADDR_W     = 32,
  parameter int unsigned          NEST_DEPTH = 4,
  parameter logic [ADDR_W-1:0]    EXC_VECTOR = 32'hBFC0_0380,
  localparam int unsigned         LVL_W      = (NEST_DEPTH > 0) ? $clog2(NEST_DEPTH + 1) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              exc_valid,
  input  logic [4:0]        exc_code,
  input  logic [ADDR_W-1:0] exc_pc,
  input  logic              exc_delay,
  input  logic              eret_valid,
  input  logic [ADDR_W-1:0] eret_pc,
  input  logic              eret_delay,
  output logic              req_ready,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [ADDR_W-1:0] wr_data,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  input  logic              redirect_ready,
  output logic              status_exl,
  output logic              status_erl,
  output logic [ADDR_W-1:0] epc,
  output logic [ADDR_W-1:0] error_epc,
  output logic              cause_bd,
  output logic [4:0]        cause_code,
  output logic [LVL_W-1:0]  nest_level,
  output logic              nest_ovf
);

  localparam bit HAS_STK = (NEST_DEPTH != 0);

  redir_state_t      r_state;
  logic              r_redirect_valid;
  logic [ADDR_W-1:0] r_redirect_pc;
  logic              r_exl;
  logic              r_erl;
  logic [ADDR_W-1:0] r_epc;
  logic [ADDR_W-1:0] r_error_epc;
  logic              r_bd;
  logic [4:0]        r_code;
  logic              r_ovf;

  logic              w_req_ready;
  logic              w_take_exc;
  logic              w_take_eret;
  logic              w_accept;
  logic              w_entry;
  logic              w_ret;
  logic [ADDR_W-1:0] w_ent_pc;
  logic              w_ent_dly;
  logic [4:0]        w_ent_code;
  logic [ADDR_W-1:0] w_ent_epc;
  logic [LVL_W-1:0]  w_level;
  logic [ADDR_W:0]   w_top;
  logic              w_stk_full;
  logic              w_push;
  logic              w_pop;

  // Exception beats ERET; a delay-slot ERET re-enters as a Reserved Instruction.
  assign w_req_ready = (r_state == ST_IDLE);
  assign w_take_exc  = w_req_ready & exc_valid;
  assign w_take_eret = w_req_ready & eret_valid & ~exc_valid;
  assign w_accept    = w_take_exc | w_take_eret;
  assign w_entry     = w_take_exc | (w_take_eret & eret_delay);
  assign w_ret       = w_take_eret & ~eret_delay;
  assign w_ent_pc    = w_take_exc ? exc_pc : eret_pc;
  assign w_ent_dly   = w_take_exc ? exc_delay : eret_delay;
  assign w_ent_code  = w_take_exc ? exc_code : 5'(EXC_RI);
  assign w_ent_epc   = w_ent_dly ? (w_ent_pc - ADDR_W'(4)) : w_ent_pc;

  assign w_stk_full  = (w_level == LVL_W'(NEST_DEPTH));
  assign w_push      = w_entry & r_exl & ~w_stk_full;
  assign w_pop       = w_ret & ~r_erl & (w_level != '0);

  generate
    if (HAS_STK) begin : g_stack
      exc_return_ctrl_nest_stack #(
        .DEPTH (NEST_DEPTH),
        .W     (ADDR_W + 1),
        .LVL_W (LVL_W)
      ) u_nest_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .pop       (w_pop),
        .push_data ({r_epc, r_bd}),
        .top_data  (w_top),
        .level     (w_level)
      );
    end else begin : g_no_stack
      assign w_level = '0;
      assign w_top   = '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= ST_IDLE;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_exl            <= 1'b0;
      r_erl            <= 1'b1;
      r_epc            <= '0;
      r_error_epc      <= '0;
      r_bd             <= 1'b0;
      r_code           <= '0;
      r_ovf            <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state          <= ST_REDIRECT;
            r_redirect_valid <= 1'b1;
          end
        end
        ST_REDIRECT: begin
          if (redirect_ready) begin
            r_state          <= ST_IDLE;
            r_redirect_valid <= 1'b0;
          end
        end
        default: begin
          r_state          <= ST_IDLE;
          r_redirect_valid <= 1'b0;
        end
      endcase

      // An accepted request flushes the pipeline, so a same-cycle mtc0 is dropped.
      if (w_entry) begin
        r_redirect_pc <= EXC_VECTOR;
        r_code        <= w_ent_code;
        if (!r_exl || w_push) begin
          r_epc <= w_ent_epc;
          r_bd  <= w_ent_dly;
          r_exl <= 1'b1;
        end
        if (r_exl && w_stk_full && HAS_STK) begin
          r_ovf <= 1'b1;
        end
      end else if (w_ret) begin
        if (r_erl) begin
          r_redirect_pc <= r_error_epc;
          r_erl         <= 1'b0;
        end else begin
          r_redirect_pc <= r_epc;
          if (w_pop) begin
            {r_epc, r_bd} <= w_top;
          end else begin
            r_exl <= 1'b0;
          end
        end
      end else if (wr_en) begin
        case (wr_addr)
          CP0_STATUS: begin
            r_exl <= wr_data[STATUS_EXL_BIT];
            r_erl <= wr_data[STATUS_ERL_BIT];
          end
          CP0_EPC:       r_epc       <= wr_data;
          CP0_ERROR_EPC: r_error_epc <= wr_data;
          default: ;
        endcase
      end
    end
  end

  assign req_ready      = w_req_ready;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign status_exl     = r_exl;
  assign status_erl     = r_erl;
  assign epc            = r_epc;
  assign error_epc      = r_error_epc;
  assign cause_bd       = r_bd;
  assign cause_code     = r_code;
  assign nest_level     = w_level;
  assign nest_ovf       = r_ovf;

endmodule

// File: tb/tb_exc_return_ctrl.sv
// Bench for exc_return_ctrl: directed scenarios then random traffic, all
// checked against a queue-based architectural model of CP0 exception state.
module tb_exc_return_ctrl;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] VEC   = 32'hBFC0_0380;

  logic        clk = 1'b0;
  logic        reset;
  logic        exc_valid, exc_delay, eret_valid, eret_delay;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc, eret_pc;
  logic        req_ready;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        redirect_valid, redirect_ready;
  logic [31:0] redirect_pc;
  logic        status_exl, status_erl, cause_bd, nest_ovf;
  logic [31:0] epc, error_epc;
  logic [4:0]  cause_code;
  logic [1:0]  nest_level;

  always #5 clk = ~clk;

  exc_return_ctrl #(.ADDR_W(32), .NEST_DEPTH(DEPTH), .EXC_VECTOR(VEC)) dut (
    .clk(clk), .reset(reset),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_delay(exc_delay),
    .eret_valid(eret_valid), .eret_pc(eret_pc), .eret_delay(eret_delay),
    .req_ready(req_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .redirect_ready(redirect_ready),
    .status_exl(status_exl), .status_erl(status_erl),
    .epc(epc), .error_epc(error_epc),
    .cause_bd(cause_bd), .cause_code(cause_code),
    .nest_level(nest_level), .nest_ovf(nest_ovf)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  // Architectural model: pending redirect plus CP0 fields and a save stack.
  bit          m_busy;
  logic [31:0] m_rpc, m_epc, m_eepc;
  bit          m_exl, m_erl, m_bd, m_ovf;
  logic [4:0]  m_code;
  logic [32:0] m_stk[$];

  task automatic model_entry(input logic [4:0] c, input logic [31:0] pc, input bit d);
    logic [31:0] new_epc;
    new_epc = d ? pc - 32'd4 : pc;
    if (!m_exl) begin
      m_epc = new_epc; m_bd = d; m_exl = 1;
    end else if (m_stk.size() < DEPTH) begin
      m_stk.push_back({m_epc, m_bd});
      m_epc = new_epc; m_bd = d;
    end else begin
      m_ovf = 1;
    end
    m_code = c; m_rpc = VEC; m_busy = 1;
  endtask

  task automatic model_ret();
    logic [32:0] e;
    if (m_erl) begin
      m_rpc = m_eepc; m_erl = 0;
    end else if (m_stk.size() > 0) begin
      m_rpc = m_epc;
      e = m_stk.pop_back();
      m_epc = e[32:1]; m_bd = e[0];
    end else begin
      m_rpc = m_epc; m_exl = 0;
    end
    m_busy = 1;
  endtask

  task automatic model_update();
    if (reset) begin
      m_busy = 0; m_rpc = 0; m_erl = 1; m_exl = 0; m_epc = 0; m_eepc = 0;
      m_bd = 0; m_code = 0; m_ovf = 0; m_stk.delete();
    end else if (!m_busy && exc_valid) begin
      model_entry(exc_code, exc_pc, exc_delay);
    end else if (!m_busy && eret_valid && eret_delay) begin
      model_entry(5'h0A, eret_pc, 1'b1);
    end else if (!m_busy && eret_valid) begin
      model_ret();
    end else begin
      if (m_busy && redirect_ready) m_busy = 0;
      if (wr_en) begin
        if (wr_addr == 5'd12) begin m_exl = wr_data[1]; m_erl = wr_data[2]; end
        else if (wr_addr == 5'd14) m_epc = wr_data;
        else if (wr_addr == 5'd30) m_eepc = wr_data;
      end
    end
  endtask

  task automatic check_all();
    check("req_ready", 32'(req_ready), 32'(!m_busy));
    check("redirect_valid", 32'(redirect_valid), 32'(m_busy));
    if (m_busy) check("redirect_pc", redirect_pc, m_rpc);
    check("exl", 32'(status_exl), 32'(m_exl));
    check("erl", 32'(status_erl), 32'(m_erl));
    check("epc", epc, m_epc);
    check("error_epc", error_epc, m_eepc);
    check("bd", 32'(cause_bd), 32'(m_bd));
    check("code", 32'(cause_code), 32'(m_code));
    check("nest_level", 32'(nest_level), 32'(m_stk.size()));
    check("nest_ovf", 32'(nest_ovf), 32'(m_ovf));
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic quiet();
    reset = 0; exc_valid = 0; exc_code = 0; exc_pc = 0; exc_delay = 0;
    eret_valid = 0; eret_pc = 0; eret_delay = 0;
    wr_en = 0; wr_addr = 0; wr_data = 0; redirect_ready = 1;
  endtask

  task automatic do_exc(input logic [4:0] c, input logic [31:0] pc, input bit d);
    quiet(); exc_valid = 1; exc_code = c; exc_pc = pc; exc_delay = d; step();
  endtask

  task automatic do_eret(input logic [31:0] pc, input bit d);
    quiet(); eret_valid = 1; eret_pc = pc; eret_delay = d; step();
  endtask

  task automatic finish_redirect();
    quiet(); step();
  endtask

  initial begin
    quiet();
    reset = 1;
    step();
    check("rst_erl", 32'(status_erl), 32'd1);
    check("rst_rv", 32'(redirect_valid), 32'd0);

    // ERL=1 return goes to ErrorEPC and holds while fetch stalls.
    quiet(); eret_valid = 1; eret_pc = 32'h100; redirect_ready = 0; step();
    for (int i = 0; i < 3; i++) begin
      quiet(); redirect_ready = 0; step();
      check("hold_pc", redirect_pc, 32'h0);
      check("hold_rv", 32'(redirect_valid), 32'd1);
    end
    check("erl_cleared", 32'(status_erl), 32'd0);
    finish_redirect();

    // Delay-slot exception then return.
    do_exc(5'd4, 32'h8000_1004, 1);
    check("dly_epc", epc, 32'h8000_1000);
    check("dly_vec", redirect_pc, VEC);
    finish_redirect();
    do_eret(32'h1234, 0);
    check("ret_pc", redirect_pc, 32'h8000_1000);
    check("ret_exl", 32'(status_exl), 32'd0);
    finish_redirect();

    // Nesting beyond stack depth, then unwind.
    for (int i = 1; i <= 5; i++) begin
      do_exc(5'd8, 32'(i * 16), 0);
      finish_redirect();
    end
    check("nest_lvl", 32'(nest_level), 32'd2);
    check("nest_epc", epc, 32'h30);
    check("nest_ovf", 32'(nest_ovf), 32'd1);
    for (int i = 3; i >= 1; i--) begin
      do_eret(32'h0, 0);
      check("unwind_pc", redirect_pc, 32'(i * 16));
      finish_redirect();
    end
    check("unwind_exl", 32'(status_exl), 32'd0);

    // ERET in a delay slot becomes RI.
    do_eret(32'h200, 1);
    check("ri_code", 32'(cause_code), 32'h0A);
    check("ri_epc", epc, 32'h1FC);
    check("ri_vec", redirect_pc, VEC);
    finish_redirect();
    do_eret(32'h0, 0);
    finish_redirect();

    // Exception wins over ERET; same-cycle mtc0 dropped.
    quiet(); exc_valid = 1; exc_code = 5'd12; exc_pc = 32'h40;
    eret_valid = 1; eret_pc = 32'h80; wr_en = 1; wr_addr = 5'd14; wr_data = 32'h999;
    redirect_ready = 0; step();
    check("tie_epc", epc, 32'h40);

    // Request during REDIRECT ignored; reset aborts the redirect.
    quiet(); exc_valid = 1; exc_pc = 32'h77; redirect_ready = 0; step();
    check("busy_epc", epc, 32'h40);
    quiet(); reset = 1; redirect_ready = 0; step();
    check("abort_rv", 32'(redirect_valid), 32'd0);
    check("abort_erl", 32'(status_erl), 32'd1);

    // Random traffic.
    for (int n = 0; n < 2000; n++) begin
      quiet();
      reset          = ($urandom_range(0, 99) == 0);
      exc_valid      = ($urandom_range(0, 4) == 0);
      exc_code       = 5'($urandom);
      exc_pc         = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      exc_delay      = 1'($urandom);
      eret_valid     = ($urandom_range(0, 3) == 0);
      eret_pc        = $urandom;
      eret_delay     = ($urandom_range(0, 4) == 0);
      redirect_ready = ($urandom_range(0, 9) < 6);
      wr_en          = ($urandom_range(0, 6) == 0);
      case ($urandom_range(0, 3))
        0: wr_addr = 5'd12;
        1: wr_addr = 5'd14;
        2: wr_addr = 5'd30;
        default: wr_addr = 5'($urandom);
      endcase
      wr_data = $urandom;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
